keypad_param_editor: RTL
========================

// Module: keypad_param_editor
// PURPOSE
//  Parametrised 4x4 keypad front-end for editing NUM_PARAMS threshold registers.
//  - Debounces the matrix and emits one event per press.
//  - Runs the select/enter/accept dialogue and range-checks the entered value.
//  - Issues a one-cycle update strobe to the parameter bank.
//  - Sits between the keypad pins and the threshold register file of the irrigation controller.
// PARAMETERS
//  NUM_PARAMS    9     editable params, 1..9 (selected with digit key 1..NUM_PARAMS)
//  GROUP_SIZE    3     params per ordered group; NUM_PARAMS must be a multiple
//  VAL_W         10    value width; MAX_VAL = 2**VAL_W-1
//  MAX_DIGITS    4     max decimal digits accepted per entry
//  DEBOUNCE_CYC  16    cycles a key pattern must be stable before it registers
//  TIMEOUT_CYC   1000  idle cycles before abort (only with KEYPAD_TIMEOUT_EN)
// PORTS
//  clk          in   1                   clock
//  reset        in   1                   async, active-high
//  keypad_row   in   4                   active-low rows
//  keypad_col   in   4                   active-low cols
//  param_cur    in   NUM_PARAMS*VAL_W    current values; param i at [i*VAL_W +: VAL_W]
//  new_value    out  VAL_W               value being written, held until next update
//  update_mask  out  NUM_PARAMS          one-hot, 1-cycle write strobe
//  reject       out  1                   1-cycle pulse: accepted entry failed range check
//  abort        out  1                   1-cycle pulse: cancel key or timeout
//  busy         out  1                   high in any state other than IDLE
//  sel_idx      out  4                   selected param index (0-based)
//  entry_value  out  VAL_W               live entry buffer, for display
//  digit_cnt    out  3                   digits currently in buffer
// BEHAVIOUR
//  Reset: every output is 0; state IDLE; buffer, debounce and timer counters are 0.
//  Keymap (row r, col c, 0-based):
//    r0: 1 2 3 A    r1: 4 5 6 B    r2: 7 8 9 C    r3: E 0 F D
//  Key decoding:
//    - A key is valid only when exactly one row and one col are low.
//    - Any other pattern means no key.
//  Debounce:
//    - The counter reloads whenever the pattern changes.
//    - After DEBOUNCE_CYC stable cycles on a valid key, exactly one key_evt is raised.
//    - No further key_evt until a no-key pattern has been stable for DEBOUNCE_CYC cycles.
//  FSM:
//    - IDLE: A -> SEL. All other keys are ignored.
//    - SEL: digit d with 1<=d<=NUM_PARAMS sets sel_idx=d-1, clears the buffer, -> ENTRY.
//      Any other digit is ignored.
//    - ENTRY:
//      - Digit d: buffer = buffer*10+d and digit_cnt++.
//        Ignored if digit_cnt==MAX_DIGITS or the result would exceed MAX_VAL (no wrap).
//      - B: buffer/=10, digit_cnt--. No-op when digit_cnt==0.
//      - E: buffer=0, digit_cnt=0.
//      - F: -> CHECK.
//    - CHECK (1 cycle): let g=sel_idx%GROUP_SIZE.
//      - lo = param_cur[sel_idx-1] when g>0, else 0.
//      - hi = param_cur[sel_idx+1] when g<GROUP_SIZE-1, else MAX_VAL+1.
//      - Pass iff lo < buffer < hi, with buffer>0 always required.
//      - Pass: update_mask[sel_idx]=1 and new_value=buffer.
//      - Fail: reject=1.
//      - Either way -> IDLE.
//    - C in SEL or ENTRY: abort=1 -> IDLE. Buffer and params are untouched.
//    - D is reserved and ignored in every state.
//  Latency: F key_evt at cycle N; CHECK at N+1; update_mask/reject asserted in N+2 only.
//  update_mask, reject and abort are never asserted together. Each lasts 1 cycle.
//  param_cur is sampled only in CHECK.
//  An async reset mid-entry discards the entry; no strobe is issued.
// CONFIGURATION
//  KEYPAD_TIMEOUT_EN:
//    - Defined: in SEL/ENTRY, a counter restarts on every key_evt.
//      On reaching TIMEOUT_CYC it raises abort=1 and goes to IDLE.
//    - Undefined: no timer; SEL/ENTRY wait indefinitely.
// TESTING
//  1. Press A, 2, 4, 5, 0, F with params 1..3 = 300,600,900 -> new_value=450, update_mask=0x002 at N+2.
//  2. Select param 1, enter 700, F with the same params -> reject=1, update_mask=0, state IDLE.
//  3. Enter 1,0,2,4 -> buffer stays 102 (1024>1023). Press B -> 10. Press E -> 0, digit_cnt=0.
//  4. Bounce the key 1 for 10 cycles, then hold it 40 cycles -> exactly one key_evt.
//     Press two keys at once -> no event.
//  5. Press A, 3, then idle TIMEOUT_CYC+1 cycles with KEYPAD_TIMEOUT_EN -> abort pulse, busy=0.
//     Without the macro -> busy stays 1.
//  6. Assert reset during ENTRY with buffer=55 -> all outputs 0, IDLE; a following F is ignored.

Source files
------------

// File: rtl/keypad_param_editor.sv
// keypad_param_editor: 4x4 keypad front-end for editing NUM_PARAMS threshold
// registers. Scans are synchronised and debounced into single key events, which
// drive a select/enter/accept dialogue ending in a range-checked write strobe.
// Optional build macro KEYPAD_TIMEOUT_EN adds an inactivity abort in SEL/ENTRY.
module keypad_param_editor #(
   parameter int unsigned NUM_PARAMS   = 9,
   parameter int unsigned GROUP_SIZE   = 3,
   parameter int unsigned VAL_W        = 10,
   parameter int unsigned MAX_DIGITS   = 4,
   parameter int unsigned DEBOUNCE_CYC = 16,
   parameter int unsigned TIMEOUT_CYC  = 1000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [3:0]                  keypad_row,
   input  logic [3:0]                  keypad_col,
   input  logic [NUM_PARAMS*VAL_W-1:0] param_cur,
   output logic [VAL_W-1:0]            new_value,
   output logic [NUM_PARAMS-1:0]       update_mask,
   output logic                        reject,
   output logic                        abort,
   output logic                        busy,
   output logic [3:0]                  sel_idx,
   output logic [VAL_W-1:0]            entry_value,
   output logic [2:0]                  digit_cnt
);

   localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
   localparam int unsigned EXT_W = VAL_W + 4;
   localparam logic [VAL_W-1:0] MAX_VAL = '1;
   localparam logic [3:0] KEY_A = 4'hA, KEY_B = 4'hB, KEY_C = 4'hC;
   localparam logic [3:0] KEY_E = 4'hE, KEY_F = 4'hF;

   typedef enum logic [1:0] {IDLE, SEL, ENTRY, CHECK} state_t;

   state_t state_q, state_d;
   logic [3:0] row_s1_q, row_s2_q, col_s1_q, col_s2_q;
   logic [7:0] pat_q, pat_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic armed_q, armed_d, key_evt_q, key_evt_d;
   logic [3:0] key_code_q, key_code_d;
   logic [VAL_W-1:0] buf_q, buf_d, new_value_q, new_value_d;
   logic [2:0] cnt_q, cnt_d;
   logic [3:0] sel_q, sel_d;
   logic [NUM_PARAMS-1:0] mask_q, mask_d;
   logic reject_q, reject_d, abort_q, abort_d;

   logic [1:0] row_idx, col_idx;
   logic row_ok, col_ok, key_valid;
   logic [3:0] key_map;
   logic timeout, is_digit, is_sel_digit, pass;
   logic [EXT_W-1:0] ext;
   logic [3:0] grp, lo_idx, hi_idx;
   logic [VAL_W-1:0] lo_v;
   logic [VAL_W:0] hi_v;
   logic [VAL_W-1:0] prm [NUM_PARAMS];

   for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_prm
      assign prm[i] = param_cur[i*VAL_W +: VAL_W];
   end

   // Decode the synchronised scan: exactly one low row and one low col is a key
   always_comb begin
      row_ok  = 1'b1;
      col_ok  = 1'b1;
      row_idx = '0;
      col_idx = '0;
      case (row_s2_q)
         4'b1110: row_idx = 2'd0;
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: row_ok = 1'b0;
      endcase
      case (col_s2_q)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: col_ok = 1'b0;
      endcase
      key_valid = row_ok & col_ok;
      case ({row_idx, col_idx})
         4'd0:  key_map = 4'd1;
         4'd1:  key_map = 4'd2;
         4'd2:  key_map = 4'd3;
         4'd3:  key_map = KEY_A;
         4'd4:  key_map = 4'd4;
         4'd5:  key_map = 4'd5;
         4'd6:  key_map = 4'd6;
         4'd7:  key_map = KEY_B;
         4'd8:  key_map = 4'd7;
         4'd9:  key_map = 4'd8;
         4'd10: key_map = 4'd9;
         4'd11: key_map = KEY_C;
         4'd12: key_map = KEY_E;
         4'd13: key_map = 4'd0;
         4'd14: key_map = KEY_F;
         default: key_map = 4'hD;
      endcase
   end

   // Debounce: one event per stable press, re-armed only by a stable release
   always_comb begin
      pat_d      = {row_s2_q, col_s2_q};
      db_cnt_d   = db_cnt_q;
      armed_d    = armed_q;
      key_evt_d  = 1'b0;
      key_code_d = key_code_q;
      if (pat_d != pat_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
         db_cnt_d = DB_W'(DEBOUNCE_CYC);
         if (key_valid) begin
            key_evt_d  = armed_q;
            armed_d    = 1'b0;
            key_code_d = key_map;
         end else begin
            armed_d = 1'b1;
         end
      end else if (db_cnt_q < DB_W'(DEBOUNCE_CYC - 1)) begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
   end

`ifdef KEYPAD_TIMEOUT_EN
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMR_W-1:0] tmr_q, tmr_d;

   // Inactivity timer: runs only in SEL/ENTRY, restarted by every key event
   always_comb begin
      tmr_d = '0;
      if ((state_q == SEL || state_q == ENTRY) && !key_evt_q && !timeout)
         tmr_d = tmr_q + 1'b1;
   end

   // Timer register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) tmr_q <= '0;
      else       tmr_q <= tmr_d;
   end

   assign timeout = (state_q == SEL || state_q == ENTRY) && !key_evt_q &&
                    (tmr_q == TMR_W'(TIMEOUT_CYC));
`else
   assign timeout = 1'b0;
`endif

   assign is_digit     = (key_code_q <= 4'd9);
   assign is_sel_digit = (key_code_q != 4'd0) && (32'(key_code_q) <= NUM_PARAMS);
   assign ext          = EXT_W'(buf_q) * EXT_W'(10) + EXT_W'(key_code_q);

   // Range neighbours come from the same group only; the group ends are open
   assign grp    = 4'(32'(sel_q) % GROUP_SIZE);
   assign lo_idx = (grp > 4'd0) ? sel_q - 4'd1 : sel_q;
   assign hi_idx = (grp < 4'(GROUP_SIZE - 1)) ? sel_q + 4'd1 : sel_q;
   assign lo_v   = (grp > 4'd0) ? prm[lo_idx] : '0;
   assign hi_v   = (grp < 4'(GROUP_SIZE - 1)) ? {1'b0, prm[hi_idx]} : {1'b1, {VAL_W{1'b0}}};
   assign pass   = (buf_q != '0) && (buf_q > lo_v) && ({1'b0, buf_q} < hi_v);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic for the edit dialogue
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (key_evt_q && key_code_q == KEY_A) state_d = SEL;
         SEL: begin
            if (timeout) state_d = IDLE;
            else if (key_evt_q) begin
               if (key_code_q == KEY_C)  state_d = IDLE;
               else if (is_sel_digit)    state_d = ENTRY;
            end
         end
         ENTRY: begin
            if (timeout) state_d = IDLE;
            else if (key_evt_q) begin
               if (key_code_q == KEY_C)      state_d = IDLE;
               else if (key_code_q == KEY_F) state_d = CHECK;
            end
         end
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Buffer editing and strobe generation
   always_comb begin
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      new_value_d = new_value_q;
      mask_d      = '0;
      reject_d    = 1'b0;
      abort_d     = 1'b0;
      case (state_q)
         SEL: begin
            if (timeout) abort_d = 1'b1;
            else if (key_evt_q) begin
               if (key_code_q == KEY_C) abort_d = 1'b1;
               else if (is_sel_digit) begin
                  sel_d = key_code_q - 4'd1;
                  buf_d = '0;
                  cnt_d = '0;
               end
            end
         end
         ENTRY: begin
            if (timeout) abort_d = 1'b1;
            else if (key_evt_q) begin
               if (is_digit) begin
                  if (cnt_q != 3'(MAX_DIGITS) && ext <= EXT_W'(MAX_VAL)) begin
                     buf_d = ext[VAL_W-1:0];
                     cnt_d = cnt_q + 3'd1;
                  end
               end else if (key_code_q == KEY_B) begin
                  if (cnt_q != 3'd0) begin
                     buf_d = buf_q / VAL_W'(10);
                     cnt_d = cnt_q - 3'd1;
                  end
               end else if (key_code_q == KEY_E) begin
                  buf_d = '0;
                  cnt_d = '0;
               end else if (key_code_q == KEY_C) begin
                  abort_d = 1'b1;
               end
            end
         end
         CHECK: begin
            if (pass) begin
               mask_d      = NUM_PARAMS'(1) << sel_q;
               new_value_d = buf_q;
            end else begin
               reject_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Synchroniser, debounce and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_s1_q    <= '1;
         row_s2_q    <= '1;
         col_s1_q    <= '1;
         col_s2_q    <= '1;
         pat_q       <= '1;
         db_cnt_q    <= '0;
         armed_q     <= 1'b0;
         key_evt_q   <= 1'b0;
         key_code_q  <= '0;
         buf_q       <= '0;
         cnt_q       <= '0;
         sel_q       <= '0;
         new_value_q <= '0;
         mask_q      <= '0;
         reject_q    <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         row_s1_q    <= keypad_row;
         row_s2_q    <= row_s1_q;
         col_s1_q    <= keypad_col;
         col_s2_q    <= col_s1_q;
         pat_q       <= pat_d;
         db_cnt_q    <= db_cnt_d;
         armed_q     <= armed_d;
         key_evt_q   <= key_evt_d;
         key_code_q  <= key_code_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         new_value_q <= new_value_d;
         mask_q      <= mask_d;
         reject_q    <= reject_d;
         abort_q     <= abort_d;
      end
   end

   assign new_value   = new_value_q;
   assign update_mask = mask_q;
   assign reject      = reject_q;
   assign abort       = abort_q;
   assign busy        = (state_q != IDLE);
   assign sel_idx     = sel_q;
   assign entry_value = buf_q;
   assign digit_cnt   = cnt_q;

endmodule
